// File: rtl/mdu_seq_pkg.sv
// rtl/mdu_seq_pkg.sv - shared EX-stage encodings: ALU ctrl, MDU ops, MDU FSM states
package mdu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_ctrl_e;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_DIVU  = 2'b01;
  localparam logic [1:0] MDU_MTHI  = 2'b10;
  localparam logic [1:0] MDU_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one combinational restoring-divide step on {rem,quo}
module mdu_div_step
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor on entry, so the shifted value is < 2*divisor and the kept difference fits WIDTH bits
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative MULTU/DIVU sequencer owning HI/LO, with pipeline stall request
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  // acc_q holds {product_hi, multiplier/product_lo} for MUL and {rem, quo} for DIV
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic             accept, last_iter;

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (start | mf_req);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  assign accept    = start & ~flush & ~busy;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_q[2*WIDTH-1:WIDTH]),
    .quo      (acc_q[WIDTH-1:0]),
    .divisor  (opnd_q),
    .rem_next (div_rem),
    .quo_next (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == MDU_MULTU)                         state_d = MUL;
          else if (op == MDU_DIVU && data2 != '0)      state_d = DIV;
        end
      end
      MUL, DIV: begin
        if (flush)          state_d = IDLE;
        else if (last_iter) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            case (op)
              MDU_MULTU: begin
                opnd_q <= data1;
                acc_q  <= {{WIDTH{1'b0}}, data2};
              end
              MDU_DIVU: begin
                if (data2 != '0) begin
                  opnd_q <= data2;
                  acc_q  <= {{WIDTH{1'b0}}, data1};
                end else begin
                  hi_q   <= data1;
                  lo_q   <= '1;
                  done_q <= 1'b1;
                end
              end
              MDU_MTHI: hi_q <= data1;
              default:  lo_q <= data1;
            endcase
          end
        end
        MUL: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DIV: begin
          acc_q <= {div_rem, div_quo};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIN: begin
          if (!flush) begin
            hi_q   <= acc_q[2*WIDTH-1:WIDTH];
            lo_q   <= acc_q[WIDTH-1:0];
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against a cycle-level arithmetic model
module tb_mdu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, mf_req, flush;
  logic [1:0]    op;
  logic [W-1:0]  data1, data2;
  logic          busy, stall_req, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .data1     (data1),
    .data2     (data2),
    .mf_req    (mf_req),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted MULTU/DIVU occupies the unit for W+1 cycles, then HI/LO take the arithmetic result
  logic [W-1:0]   m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic           m_done = 1'b0;
  int             m_rem = 0;
  logic [2*W-1:0] prod;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem = 0;
        else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        case (op)
          2'b00: begin
            prod = {{W{1'b0}}, data1} * {{W{1'b0}}, data2};
            p_hi = prod[2*W-1:W]; p_lo = prod[W-1:0];
            m_rem = W + 1;
          end
          2'b01: begin
            if (data2 == 0) begin
              m_hi = data1; m_lo = '1; m_done = 1'b1;
            end else begin
              p_hi = data1 % data2; p_lo = data1 / data2;
              m_rem = W + 1;
            end
          end
          2'b10: m_hi = data1;
          default: m_lo = data1;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", W'(busy), W'(m_rem != 0));
    chk("done", W'(done), W'(m_done));
    chk("stall_req", W'(stall_req), W'((m_rem != 0) && (start || mf_req)));
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", W'(busy), '0);
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; data1 = '0; data2 = '0; mf_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    busy_cnt = 0; done_cnt = 0;
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(60);
    chk("mul_max_hi", hi, 32'hFFFF_FFFE);
    chk("mul_max_lo", lo, 32'h0000_0001);
    @(posedge clk); #1;
    chk("mul_max_done_pulses", W'(done_cnt), W'(1));
    chk("mul_max_busy_cycles", W'(busy_cnt), W'(33));

    issue(2'b01, 32'd100, 32'd7);
    wait_idle(60);
    chk("div_100_7_hi", hi, 32'd2);
    chk("div_100_7_lo", lo, 32'd14);
    @(posedge clk); #1;

    busy_cnt = 0; done_cnt = 0;
    issue(2'b01, 32'd5, 32'd0);
    chk("div0_done", W'(done), W'(1));
    chk("div0_hi", hi, 32'd5);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("div0_busy_cycles", W'(busy_cnt), '0);
    chk("div0_done_pulses", W'(done_cnt), W'(1));

    issue(2'b00, 32'd3, 32'd4);
    mf_req = 1'b1;
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      if (!stall_req) break;
      stalls++;
      @(posedge clk); #1;
    end
    chk("mf_stall_cycles", W'(stalls), W'(33));
    chk("mf_read_lo", lo, 32'd12);
    chk("mf_read_hi", hi, 32'd0);
    mf_req = 1'b0;

    start = 1'b1; op = 2'b10; data1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo, 32'd12);
    op = 2'b11; data1 = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

    start = 1'b1; flush = 1'b1; op = 2'b10; data1 = 32'h55;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_hi", hi, 32'hDEAD_BEEF);

    done_cnt = 0;
    issue(2'b01, 32'd1000, 32'd10);
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", W'(busy), '0);
    chk("flush_hi", hi, 32'hDEAD_BEEF);
    chk("flush_lo", lo, 32'h1234_5678);
    repeat (2) @(posedge clk); #1;
    chk("flush_done_pulses", W'(done_cnt), '0);

    issue(2'b00, 32'd6, 32'd7);
    wait_idle(60);
    chk("mul_6_7_lo", lo, 32'd42);
    chk("mul_6_7_hi", hi, 32'd0);

    issue(2'b00, 32'd9, 32'd9);
    mf_req = 1'b1;
    repeat (13) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_busy", W'(busy), '0);
    chk("arst_stall", W'(stall_req), '0);
    chk("arst_done", W'(done), '0);
    mf_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b11, 32'd1, 32'd0);
    chk("post_rst_mtlo", lo, 32'd1);
    chk("post_rst_hi", hi, '0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
